// File: rtl/io_port_bank.sv
// rtl/io_port_bank.sv - memory-mapped input/output port bank with debounce, W1C change flags and 7-segment drive
//
// Ports:
//   clock, reset           single clock, asynchronous active-high reset
//   io_sel, addr, we       bus select, byte address (word = addr[7:2]), write strobe
//   wdata, rdata           write data, registered read data (1-cycle latency)
//   in_raw                 NUM_IN asynchronous input channels, DATA_W bits each
//   out_port               NUM_OUT CPU-writable output registers
//   hex                    six active-low 7-segment digits driven from OUT[0]
//   irq                    registered level interrupt, |(STATUS & IRQ_EN)

module io_port_bank #(
    parameter int DATA_W       = 32,
    parameter int NUM_IN       = 2,
    parameter int NUM_OUT      = 2,
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      io_sel,
    input  logic [7:0]                addr,
    input  logic                      we,
    input  logic [DATA_W-1:0]         wdata,
    output logic [DATA_W-1:0]         rdata,
    input  logic [NUM_IN*DATA_W-1:0]  in_raw,
    output logic [NUM_OUT*DATA_W-1:0] out_port,
    output logic [41:0]               hex,
    output logic                      irq
);

    localparam int CNT_W = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [5:0]       W_STATUS   = 6'(NUM_IN + NUM_OUT);
    localparam logic [5:0]       W_IRQ_EN   = 6'(NUM_IN + NUM_OUT + 1);
    localparam logic [5:0]       W_HEX_CTRL = 6'(NUM_IN + NUM_OUT + 2);

    logic [5:0]        word;
    logic              wr;
    logic              rd;
    logic              addr_unused;

    logic [DATA_W-1:0] sync_a [NUM_IN];
    logic [DATA_W-1:0] sync_b [NUM_IN];
    logic [DATA_W-1:0] stable [NUM_IN];
    logic [CNT_W-1:0]  db_cnt [NUM_IN];
    logic [NUM_IN-1:0] accept;

    logic [DATA_W-1:0] out_reg [NUM_OUT];
    logic [NUM_IN-1:0] status;
    logic [NUM_IN-1:0] status_clr;
    logic [NUM_IN-1:0] irq_en;
    logic [5:0]        hex_ctrl;
    logic [DATA_W-1:0] rd_word;

    assign word        = addr[7:2];
    assign wr          = io_sel & we;
    assign rd          = io_sel & ~we;
    assign addr_unused = &addr[1:0];

    // A channel is accepted on the DEBOUNCE_CYC-th consecutive cycle that
    // the synchronised value differs from the stable one.
    always_comb begin
        accept = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            accept[i] = (sync_b[i] != stable[i]) && (db_cnt[i] == CNT_LAST);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_IN; i++) begin
                sync_a[i] <= '0;
                sync_b[i] <= '0;
                stable[i] <= '0;
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_IN; i++) begin
                sync_a[i] <= in_raw[i*DATA_W +: DATA_W];
                sync_b[i] <= sync_a[i];
                if (accept[i]) begin
                    stable[i] <= sync_b[i];
                    db_cnt[i] <= '0;
                end else if (sync_b[i] != stable[i]) begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    assign status_clr = (wr && word == W_STATUS) ? wdata[NUM_IN-1:0] : '0;

    // Register file; a set event overrides a simultaneous W1C of the same bit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int j = 0; j < NUM_OUT; j++) begin
                out_reg[j] <= '0;
            end
            status   <= '0;
            irq_en   <= '0;
            hex_ctrl <= '0;
            irq      <= 1'b0;
        end else begin
            for (int j = 0; j < NUM_OUT; j++) begin
                if (wr && word == 6'(NUM_IN + j)) begin
                    out_reg[j] <= wdata;
                end
            end
            if (wr && word == W_IRQ_EN) begin
                irq_en <= wdata[NUM_IN-1:0];
            end
            if (wr && word == W_HEX_CTRL) begin
                hex_ctrl <= wdata[5:0];
            end
            status <= (status & ~status_clr) | accept;
            irq    <= |(status & irq_en);
        end
    end

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (word == 6'(i)) begin
                rd_word = stable[i];
            end
        end
        for (int j = 0; j < NUM_OUT; j++) begin
            if (word == 6'(NUM_IN + j)) begin
                rd_word = out_reg[j];
            end
        end
        if (word == W_STATUS) begin
            rd_word = DATA_W'(status);
        end
        if (word == W_IRQ_EN) begin
            rd_word = DATA_W'(irq_en);
        end
        if (word == W_HEX_CTRL) begin
            rd_word = DATA_W'(hex_ctrl);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if (rd) begin
            rdata <= rd_word;
        end
    end

    always_comb begin
        out_port = '0;
        for (int j = 0; j < NUM_OUT; j++) begin
            out_port[j*DATA_W +: DATA_W] = out_reg[j];
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0: seg7 = 7'b1000000;
            4'h1: seg7 = 7'b1111001;
            4'h2: seg7 = 7'b0100100;
            4'h3: seg7 = 7'b0110000;
            4'h4: seg7 = 7'b0011001;
            4'h5: seg7 = 7'b0010010;
            4'h6: seg7 = 7'b0000010;
            4'h7: seg7 = 7'b1111000;
            4'h8: seg7 = 7'b0000000;
            4'h9: seg7 = 7'b0010000;
            4'hA: seg7 = 7'b0001000;
            4'hB: seg7 = 7'b0000011;
            4'hC: seg7 = 7'b1000110;
            4'hD: seg7 = 7'b0100001;
            4'hE: seg7 = 7'b0000110;
            default: seg7 = 7'b0001110;
        endcase
    endfunction

    always_comb begin
        hex = '0;
        for (int d = 0; d < 6; d++) begin
            hex[d*7 +: 7] = hex_ctrl[d] ? 7'b1111111 : seg7(out_reg[0][d*4 +: 4]);
        end
    end

endmodule

// File: tb/tb_io_port_bank.sv
// tb/tb_io_port_bank.sv - directed and randomized checks of io_port_bank against a reference model

module tb_io_port_bank;

    localparam int DW       = 32;
    localparam int NI       = 2;
    localparam int NO       = 2;
    localparam int DB       = 4;
    localparam int W_STATUS = NI + NO;
    localparam int W_IRQEN  = NI + NO + 1;
    localparam int W_HEX    = NI + NO + 2;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             io_sel = 1'b0;
    logic [7:0]       addr = '0;
    logic             we = 1'b0;
    logic [DW-1:0]    wdata = '0;
    logic [DW-1:0]    rdata;
    logic [NI*DW-1:0] in_raw = '0;
    logic [NO*DW-1:0] out_port;
    logic [41:0]      hex;
    logic             irq;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [DW-1:0] m_d1 [NI];
    logic [DW-1:0] m_d2 [NI];
    logic [DW-1:0] m_stable [NI];
    int            m_run [NI];
    logic [DW-1:0] m_out [NO];
    logic [NI-1:0] m_status;
    logic [NI-1:0] m_irqen;
    logic [5:0]    m_hexctl;
    logic [DW-1:0] m_rdata;
    logic          m_irq;

    io_port_bank #(.DATA_W(DW), .NUM_IN(NI), .NUM_OUT(NO), .DEBOUNCE_CYC(DB)) dut (
        .clock(clock), .reset(reset), .io_sel(io_sel), .addr(addr), .we(we),
        .wdata(wdata), .rdata(rdata), .in_raw(in_raw), .out_port(out_port),
        .hex(hex), .irq(irq)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] seg_ref(input logic [3:0] v);
        case (v)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    function automatic logic [41:0] model_hex();
        logic [41:0] h;
        for (int d = 0; d < 6; d++) begin
            h[7*d +: 7] = m_hexctl[d] ? 7'b1111111 : seg_ref(m_out[0][4*d +: 4]);
        end
        return h;
    endfunction

    function automatic logic [NO*DW-1:0] model_out();
        logic [NO*DW-1:0] v;
        for (int j = 0; j < NO; j++) v[j*DW +: DW] = m_out[j];
        return v;
    endfunction

    function automatic logic [DW-1:0] model_word(input int w);
        if (w < NI) return m_stable[w];
        if (w < NI + NO) return m_out[w-NI];
        if (w == W_STATUS) return DW'(m_status);
        if (w == W_IRQEN) return DW'(m_irqen);
        if (w == W_HEX) return DW'(m_hexctl);
        return '0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_d1[i] = '0; m_d2[i] = '0; m_stable[i] = '0; m_run[i] = 0;
        end
        for (int j = 0; j < NO; j++) m_out[j] = '0;
        m_status = '0; m_irqen = '0; m_hexctl = '0; m_rdata = '0; m_irq = 1'b0;
    endtask

    // One rising edge: every result is derived from pre-edge model state.
    task automatic model_step();
        int            w;
        logic          nirq;
        logic [NI-1:0] clr;
        logic [NI-1:0] set;
        w    = int'(addr[7:2]);
        nirq = |(m_status & m_irqen);
        clr  = '0;
        set  = '0;
        if (io_sel && !we) m_rdata = model_word(w);
        if (io_sel && we) begin
            if (w >= NI && w < NI + NO) m_out[w-NI] = wdata;
            else if (w == W_STATUS) clr = wdata[NI-1:0];
            else if (w == W_IRQEN) m_irqen = wdata[NI-1:0];
            else if (w == W_HEX) m_hexctl = wdata[5:0];
        end
        for (int ch = 0; ch < NI; ch++) begin
            // Debouncer sees the raw input from two edges ago.
            if (m_d2[ch] != m_stable[ch]) begin
                m_run[ch]++;
                if (m_run[ch] == DB) begin
                    m_stable[ch] = m_d2[ch];
                    m_run[ch] = 0;
                    set[ch] = 1'b1;
                end
            end else begin
                m_run[ch] = 0;
            end
            m_d2[ch] = m_d1[ch];
            m_d1[ch] = in_raw[ch*DW +: DW];
        end
        m_status = (m_status & ~clr) | set;
        m_irq = nirq;
    endtask

    task automatic tick();
        @(posedge clock);
        if (reset) model_reset();
        else model_step();
        @(negedge clock);
        check("rdata", 64'(rdata), 64'(m_rdata));
        check("out_port", 64'(out_port), 64'(model_out()));
        check("irq", 64'(irq), 64'(m_irq));
        check("hex", 64'(hex), 64'(model_hex()));
    endtask

    task automatic bus_write(input int w, input logic [DW-1:0] d);
        io_sel = 1'b1; we = 1'b1; addr = 8'(w * 4); wdata = d;
        tick();
        io_sel = 1'b0; we = 1'b0;
    endtask

    task automatic bus_read(input int w);
        io_sel = 1'b1; we = 1'b0; addr = 8'(w * 4);
        tick();
        io_sel = 1'b0;
    endtask

    initial begin
        int r;
        model_reset();
        repeat (2) tick();
        reset = 1'b0;

        // Mid-operation reset, then every word reads zero
        bus_write(NI, 32'hDEAD_BEEF);
        bus_write(W_IRQEN, 32'h3);
        bus_write(W_HEX, 32'h3F);
        in_raw[0 +: DW] = 32'h1234;
        repeat (3) tick();
        reset = 1'b1;
        in_raw = '0;
        model_reset();
        repeat (3) tick();
        reset = 1'b0;
        for (int w = 0; w <= W_HEX + 1; w++) begin
            bus_read(w);
            check("reset_read", 64'(rdata), 64'h0);
        end
        check("reset_hex", 64'(hex), 64'({6{7'b1000000}}));
        check("reset_irq", 64'(irq), 64'h0);

        // Clean change on ch0
        in_raw[0 +: DW] = 32'h0000_0224;
        repeat (5) tick();
        bus_read(0);
        check("in0_early", 64'(rdata), 64'h0);
        bus_read(0);
        check("in0_new", 64'(rdata), 64'h224);
        bus_read(W_STATUS);
        check("status_set", 64'(rdata), 64'h1);

        // Three-cycle glitch on ch1 is rejected
        in_raw[DW +: DW] = 32'h1;
        repeat (3) tick();
        in_raw[DW +: DW] = 32'h0;
        repeat (8) tick();
        bus_read(1);
        check("in1_glitch", 64'(rdata), 64'h0);
        bus_read(W_STATUS);
        check("status_glitch", 64'(rdata), 64'h1);

        // Output register, hex digits, readback, blanking
        bus_write(NI, 32'h0012_3ABC);
        check("hex_digits", 64'(hex), 64'({7'b1111001, 7'b0100100, 7'b0110000,
                                           7'b0001000, 7'b0000011, 7'b1000110}));
        bus_read(NI);
        check("out0_read", 64'(rdata), 64'h0012_3ABC);
        bus_write(W_HEX, 32'h30);
        check("hex_blank", 64'(hex[41:28]), 64'h3FFF);
        check("hex_unblank", 64'(hex[27:0]), 64'({7'b0110000, 7'b0001000, 7'b0000011, 7'b1000110}));

        // Interrupt raise and W1C/set collision
        bus_write(W_STATUS, 32'h3);
        bus_write(W_IRQEN, 32'h1);
        check("irq_idle", 64'(irq), 64'h0);
        in_raw[0 +: DW] = 32'h555;
        repeat (6) tick();
        check("irq_not_yet", 64'(irq), 64'h0);
        tick();
        check("irq_high", 64'(irq), 64'h1);
        in_raw[0 +: DW] = 32'h0AA;
        repeat (5) tick();
        bus_write(W_STATUS, 32'h1);
        bus_read(W_STATUS);
        check("w1c_collision", 64'(rdata), 64'h1);
        bus_write(W_STATUS, 32'h1);
        check("irq_hold", 64'(irq), 64'h1);
        tick();
        check("irq_drop", 64'(irq), 64'h0);
        bus_read(W_STATUS);
        check("w1c_clear", 64'(rdata), 64'h0);

        // Unmapped and read-only writes are ignored
        bus_write(20, 32'hFFFF_FFFF);
        bus_write(0, 32'hFFFF_FFFF);
        bus_read(20);
        check("unmapped_read", 64'(rdata), 64'h0);
        bus_read(0);
        check("in0_ro", 64'(rdata), 64'h0AA);
        check("out_unchanged", 64'(out_port), {32'h0, 32'h0012_3ABC});

        // Randomized traffic against the model
        for (int n = 0; n < 500; n++) begin
            for (int ch = 0; ch < NI; ch++) begin
                if ($urandom_range(7) == 0) in_raw[ch*DW +: DW] = $urandom();
            end
            r = $urandom_range(11);
            if (r == 0 && $urandom_range(15) == 0) begin
                reset = 1'b1;
                model_reset();
                #1;
                check("async_rdata", 64'(rdata), 64'h0);
                check("async_out", 64'(out_port), 64'h0);
                tick();
                reset = 1'b0;
            end else if (r <= 3) begin
                io_sel = 1'b0; we = (r == 3); wdata = $urandom(); addr = 8'($urandom());
                tick();
                we = 1'b0;
            end else begin
                io_sel = 1'b1;
                we = (r >= 8);
                wdata = $urandom();
                if ($urandom_range(9) == 0) addr = 8'($urandom());
                else addr = {6'($urandom_range(W_HEX + 1)), 2'($urandom())};
                tick();
                io_sel = 1'b0; we = 1'b0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
